// File: rtl/memory.sv
//==============================================================================
// Module   : memory
// Purpose  : Unified data-memory map: 16K x 16 RAM, four display registers,
//            and a read-only keyboard port, with combinational reads.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module memory (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] address,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [15:0] kbd,
  output logic [15:0] out,
  output logic [15:0] display0,
  output logic [15:0] display1,
  output logic [15:0] display2,
  output logic [15:0] display3
);

  localparam logic [12:0] c_disp_base = 13'h1000;  // 0x4000 >> 2
  localparam logic [14:0] c_kbd_addr  = 15'h6000;

  logic [15:0] r_ram  [0:16383];
  logic [15:0] r_disp [0:3];

  logic w_sel_ram;
  logic w_sel_disp;
  logic w_sel_kbd;
  logic w_wr_ok;

  assign w_sel_ram  = ~address[14];
  assign w_sel_disp = (address[14:2] == c_disp_base);
  assign w_sel_kbd  = (address == c_kbd_addr);
  // Reset outranks load, so a write during reset is dropped in every region.
  assign w_wr_ok    = load & reset_n;

  // RAM is deliberately left out of reset; it keeps its contents.
  always_ff @(posedge clk) begin
    if (w_wr_ok && w_sel_ram) begin
      r_ram[address[13:0]] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_disp[i] <= 16'h0000;
      end
    end else if (w_wr_ok && w_sel_disp) begin
      r_disp[address[1:0]] <= in;
    end
  end

  always_comb begin
    out = 16'h0000;
    if (w_sel_ram) begin
      out = r_ram[address[13:0]];
    end else if (w_sel_disp) begin
      out = r_disp[address[1:0]];
    end else if (w_sel_kbd) begin
      out = kbd;
    end
  end

  assign display0 = r_disp[0];
  assign display1 = r_disp[1];
  assign display2 = r_disp[2];
  assign display3 = r_disp[3];

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
//==============================================================================
// Module   : tb_memory
// Purpose  : Directed self-checking bench for the memory map.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_memory;

  logic        clk;
  logic        reset_n;
  logic [14:0] address;
  logic [15:0] in;
  logic        load;
  logic [15:0] kbd;
  logic [15:0] out;
  logic [15:0] display0;
  logic [15:0] display1;
  logic [15:0] display2;
  logic [15:0] display3;

  int checks = 0;
  int errors = 0;

  memory dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .in       (in),
    .load     (load),
    .kbd      (kbd),
    .out      (out),
    .display0 (display0),
    .display1 (display1),
    .display2 (display2),
    .display3 (display3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    check({tag, " d0"}, display0, e0);
    check({tag, " d1"}, display1, e1);
    check({tag, " d2"}, display2, e2);
    check({tag, " d3"}, display3, e3);
  endtask

  logic [15:0] dvals [4];
  logic [15:0] rvals [10];

  initial begin
    dvals = '{16'h4567, 16'h4568, 16'h4569, 16'h456A};
    rvals = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
              16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999};

    reset_n = 1'b0; load = 1'b0; in = 16'h0000; address = 15'h0000; kbd = 16'h0000;
    step();
    reset_n = 1'b1;
    check_disp("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Display writes interleaved with idle cycles carrying 0xFFFF
    for (int i = 0; i < 4; i++) begin
      address = 15'h4000 + 15'(i); in = dvals[i]; load = 1'b1;
      step();
      check("disp wr readback", out, dvals[i]);
      load = 1'b0; in = 16'hFFFF;
      step();
      check("disp idle readback", out, dvals[i]);
    end
    check_disp("disp wr", 16'h4567, 16'h4568, 16'h4569, 16'h456A);

    for (int i = 0; i < 4; i++) begin
      address = 15'h4000 + 15'(i); load = 1'b0; in = 16'hFFFF;
      #1;
      check("disp read", out, dvals[i]);
      step();
    end
    check_disp("disp after read", 16'h4567, 16'h4568, 16'h4569, 16'h456A);

    // RAM back-to-back writes, then reads
    for (int i = 0; i < 10; i++) begin
      address = 15'(i); in = rvals[i]; load = 1'b1;
      step();
    end
    load = 1'b0; in = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      address = 15'(i);
      #1;
      check("ram read", out, rvals[i]);
      step();
    end
    address = 15'h0000; in = 16'h5555; load = 1'b1;
    step();
    load = 1'b0; in = 16'hFFFF;
    #1;
    check("ram rewrite", out, 16'h5555);

    // Top RAM word must not alias into display space
    address = 15'h3FFF; in = 16'h7E7E; load = 1'b1;
    step();
    load = 1'b0;
    check("ram top", out, 16'h7E7E);
    check_disp("ram top iso", 16'h4567, 16'h4568, 16'h4569, 16'h456A);

    // Keyboard passthrough
    address = 15'h6000;
    kbd = 16'h2380; #1; check("kbd 0", out, 16'h2380);
    step();
    kbd = 16'h2381; #1; check("kbd 1", out, 16'h2381);
    step();
    kbd = 16'h2382; #1; check("kbd 2", out, 16'h2382);
    in = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    check("kbd after wr", out, 16'h2382);
    check_disp("kbd wr iso", 16'h4567, 16'h4568, 16'h4569, 16'h456A);
    address = 15'h0000; #1; check("kbd wr ram0", out, 16'h5555);
    address = 15'h1234; in = 16'hFFFF;

    // Unmapped writes and reads
    address = 15'h4004; in = 16'hBEEF; load = 1'b1;
    step();
    load = 1'b0;
    check("unmapped 4004", out, 16'h0000);
    address = 15'h6001; load = 1'b1;
    step();
    load = 1'b0;
    check("unmapped 6001", out, 16'h0000);
    address = 15'h5FFF; #1; check("unmapped 5fff", out, 16'h0000);
    address = 15'h7FFF; #1; check("unmapped 7fff", out, 16'h0000);
    check_disp("unmapped iso", 16'h4567, 16'h4568, 16'h4569, 16'h456A);
    address = 15'h0004; #1; check("unmapped ram4", out, 16'h4444);
    address = 15'h0001; #1; check("unmapped ram1", out, 16'h1111);

    // Reset beats a concurrent display write; RAM survives reset
    reset_n = 1'b0; address = 15'h4000; in = 16'hABCD; load = 1'b1;
    step();
    check("rst out 4000", out, 16'h0000);
    check_disp("rst prio", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    address = 15'h6000; kbd = 16'h00C3; load = 1'b0;
    #1;
    check("rst kbd", out, 16'h00C3);
    address = 15'h0009; #1; check("rst ram9", out, 16'h9999);
    reset_n = 1'b1;
    step();
    address = 15'h0003; #1; check("post rst ram3", out, 16'h3333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
